bf_sequencer: RTL and testbench

Run controller for the brainfuck core `proc`. On `start`, it:
- zero-fills data memory;
- streams a program into program memory;
- resets the core, runs it under a watchdog with pause/single-step support, and reports completion status.

It sits between the host/loader and the core plus its two memories. It owns the memory write ports while not running and drives the core's `en`/`reset`.

---
 rtl/bf_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_bf_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_sequencer.sv
// bf_sequencer: zero-fills data memory, streams a program into program memory,
// then resets and runs the bf core under a watchdog with pause/single-step.
module bf_sequencer #(
    parameter int PROG_ADDR_WIDTH  = 8,
    parameter int DATA_ADDR_WIDTH  = 8,
    parameter int DATA_VALUE_WIDTH = 8,
    parameter int WDOG_WIDTH       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        pause,
    input  logic                        step,
    input  logic [WDOG_WIDTH-1:0]       wdog_limit,
    input  logic                        ld_valid,
    input  logic [7:0]                  ld_data,
    output logic                        ld_ready,
    output logic                        pmem_wen,
    output logic [PROG_ADDR_WIDTH-1:0]  pmem_addr,
    output logic [7:0]                  pmem_wdata,
    output logic                        dmem_wen,
    output logic [DATA_ADDR_WIDTH-1:0]  dmem_addr,
    output logic [DATA_VALUE_WIDTH-1:0] dmem_wdata,
    output logic                        mem_owner,
    output logic                        core_en,
    output logic                        core_reset,
    input  logic                        core_prog_ren,
    input  logic                        core_stdout_en,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  err,
    output logic [15:0]                 out_count
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RST, S_RUN, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic                         ld_ready_q, ld_ready_d;
    logic                         pmem_wen_q, pmem_wen_d;
    logic [PROG_ADDR_WIDTH-1:0]   pmem_addr_q, pmem_addr_d;
    logic [7:0]                   pmem_wdata_q, pmem_wdata_d;
    logic [PROG_ADDR_WIDTH-1:0]   ld_ptr_q, ld_ptr_d;
    logic                         dmem_wen_q, dmem_wen_d;
    logic [DATA_ADDR_WIDTH-1:0]   dmem_addr_q, dmem_addr_d;
    logic                         mem_owner_q, mem_owner_d;
    logic                         core_en_q, core_en_d;
    logic                         core_reset_q, core_reset_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [1:0]                   err_q, err_d;
    logic [15:0]                  out_count_q, out_count_d;
    logic [WDOG_WIDTH-1:0]        wdog_q, wdog_d;
    logic [1:0]                   lowcnt_q, lowcnt_d;
    logic                         en_prev_q, step_prev_q, stdout_prev_q;
    logic                         step_rise, stdout_rise, run_en;

    assign step_rise   = step & ~step_prev_q;
    assign stdout_rise = core_stdout_en & ~stdout_prev_q;
    assign run_en      = ~pause | step_rise;

    always_comb begin
        state_d      = state_q;
        ld_ready_d   = 1'b0;
        pmem_wen_d   = 1'b0;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        ld_ptr_d     = ld_ptr_q;
        dmem_wen_d   = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        mem_owner_d  = 1'b0;
        core_en_d    = 1'b0;
        core_reset_d = 1'b0;
        done_d       = done_q;
        err_d        = err_q;
        out_count_d  = out_count_q;
        wdog_d       = wdog_q;
        lowcnt_d     = lowcnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_CLEAR;
                    done_d      = 1'b0;
                    err_d       = 2'b00;
                    out_count_d = '0;
                    dmem_addr_d = '0;
                    pmem_addr_d = '0;
                    ld_ptr_d    = '0;
                    dmem_wen_d  = 1'b1;
                end
            end
            S_CLEAR: begin
                dmem_addr_d = dmem_addr_q + DATA_ADDR_WIDTH'(1);
                if (dmem_addr_q == '1) begin
                    state_d    = S_LOAD;
                    ld_ready_d = 1'b1;
                end else begin
                    dmem_wen_d = 1'b1;
                end
            end
            S_LOAD: begin
                ld_ready_d = ld_ready_q;
                // pmem_addr shows the address of the write in flight; ld_ptr runs ahead
                if (ld_valid && ld_ready_q) begin
                    pmem_wen_d   = 1'b1;
                    pmem_addr_d  = ld_ptr_q;
                    pmem_wdata_d = ld_data;
                    ld_ptr_d     = ld_ptr_q + PROG_ADDR_WIDTH'(1);
                    if ((ld_data == 8'h00) || (ld_ptr_q == '1)) ld_ready_d = 1'b0;
                end
                if (pmem_wen_q && (pmem_wdata_q == 8'h00)) begin
                    state_d      = S_RST;
                    core_en_d    = 1'b1;
                    core_reset_d = 1'b1;
                    mem_owner_d  = 1'b1;
                end else if (pmem_wen_q && (pmem_addr_q == '1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 2'b10;
                end
            end
            S_RST: begin
                state_d     = S_RUN;
                mem_owner_d = 1'b1;
                core_en_d   = run_en;
                wdog_d      = '0;
                lowcnt_d    = 2'd0;
            end
            S_RUN: begin
                mem_owner_d = 1'b1;
                if (en_prev_q)
                    lowcnt_d = core_prog_ren ? 2'd0 :
                               ((lowcnt_q == 2'd2) ? 2'd2 : lowcnt_q + 2'd1);
                if (core_en_q) wdog_d = wdog_q + WDOG_WIDTH'(1);
                if (stdout_rise && (out_count_q != 16'hFFFF)) out_count_d = out_count_q + 16'd1;
                // halt is checked first so it wins over a coincident timeout
                if (lowcnt_d == 2'd2) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    err_d       = 2'b00;
                    mem_owner_d = 1'b0;
                end else if ((wdog_limit != '0) && (wdog_d == wdog_limit)) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    err_d       = 2'b01;
                    mem_owner_d = 1'b0;
                end else begin
                    core_en_d = run_en;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d      = S_IDLE;
            ld_ready_d   = 1'b0;
            pmem_wen_d   = 1'b0;
            dmem_wen_d   = 1'b0;
            mem_owner_d  = 1'b0;
            core_en_d    = 1'b0;
            core_reset_d = 1'b0;
            done_d       = done_q;
            err_d        = err_q;
            out_count_d  = out_count_q;
            dmem_addr_d  = dmem_addr_q;
            pmem_addr_d  = pmem_addr_q;
            pmem_wdata_d = pmem_wdata_q;
            ld_ptr_d     = ld_ptr_q;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ld_ready_q    <= 1'b0;
            pmem_wen_q    <= 1'b0;
            pmem_addr_q   <= '0;
            pmem_wdata_q  <= '0;
            ld_ptr_q      <= '0;
            dmem_wen_q    <= 1'b0;
            dmem_addr_q   <= '0;
            mem_owner_q   <= 1'b0;
            core_en_q     <= 1'b0;
            core_reset_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 2'b00;
            out_count_q   <= '0;
            wdog_q        <= '0;
            lowcnt_q      <= 2'd0;
            en_prev_q     <= 1'b0;
            step_prev_q   <= 1'b0;
            stdout_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_ready_q    <= ld_ready_d;
            pmem_wen_q    <= pmem_wen_d;
            pmem_addr_q   <= pmem_addr_d;
            pmem_wdata_q  <= pmem_wdata_d;
            ld_ptr_q      <= ld_ptr_d;
            dmem_wen_q    <= dmem_wen_d;
            dmem_addr_q   <= dmem_addr_d;
            mem_owner_q   <= mem_owner_d;
            core_en_q     <= core_en_d;
            core_reset_q  <= core_reset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            out_count_q   <= out_count_d;
            wdog_q        <= wdog_d;
            lowcnt_q      <= lowcnt_d;
            en_prev_q     <= core_en_q;
            step_prev_q   <= step;
            stdout_prev_q <= core_stdout_en;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign pmem_wen   = pmem_wen_q;
    assign pmem_addr  = pmem_addr_q;
    assign pmem_wdata = pmem_wdata_q;
    assign dmem_wen   = dmem_wen_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = '0;
    assign mem_owner  = mem_owner_q;
    assign core_en    = core_en_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign out_count  = out_count_q;

endmodule

// File: tb/tb_bf_sequencer.sv
// Bench for bf_sequencer: a stand-in core drives prog_ren/stdout_en, and a
// phase-level reference model predicts every output on every cycle.
`timescale 1ns/1ps
module tb_bf_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, abort = 1'b0, pause = 1'b0, step = 1'b0;
    logic [15:0] wdog_limit = 16'd0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'd0;
    logic        ld_ready, pmem_wen, dmem_wen, mem_owner, core_en, core_reset;
    logic [7:0]  pmem_addr, pmem_wdata, dmem_addr, dmem_wdata;
    logic        core_prog_ren, core_stdout_en;
    logic        busy, done;
    logic [1:0]  err;
    logic [15:0] out_count;

    always #5 clk = ~clk;

    bf_sequencer #(
        .PROG_ADDR_WIDTH(8), .DATA_ADDR_WIDTH(8), .DATA_VALUE_WIDTH(8), .WDOG_WIDTH(16)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .abort(abort), .pause(pause), .step(step),
        .wdog_limit(wdog_limit), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
        .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .mem_owner(mem_owner), .core_en(core_en), .core_reset(core_reset),
        .core_prog_ren(core_prog_ren), .core_stdout_en(core_stdout_en),
        .busy(busy), .done(done), .err(err), .out_count(out_count)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Stand-in core: counts enabled cycles; prog_ren drops once the "program" ends.
    bit fc_rand;
    int halt_at, out_a, out_b, fc_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_cnt <= 0; core_prog_ren <= 1'b0; core_stdout_en <= 1'b0;
        end else if (core_en && core_reset) begin
            fc_cnt <= 0; core_prog_ren <= 1'b1; core_stdout_en <= 1'b0;
        end else if (core_en) begin
            fc_cnt <= fc_cnt + 1;
            if (fc_rand) begin
                core_prog_ren  <= ($urandom_range(0, 5) != 0);
                core_stdout_en <= 1'($urandom_range(0, 1));
            end else begin
                core_prog_ren  <= (fc_cnt < halt_at);
                core_stdout_en <= (fc_cnt == out_a) || (fc_cnt == out_b);
            end
        end else begin
            core_stdout_en <= 1'b0;
        end
    end

    // Reference model: phase plus plain integer bookkeeping.
    typedef enum {P_IDLE, P_CLEAR, P_LOAD, P_RST, P_RUN, P_DONE} phase_t;
    phase_t ph;
    bit e_ld_ready, e_pwen, e_dwen, e_owner, e_en, e_rst, e_busy, e_done;
    int e_paddr, e_pdata, e_daddr, e_err, e_outc;
    bit ld_open, pend, m_step_prev, m_out_prev, m_en_prev;
    int wr_ptr, lowc, wd;

    task automatic model_reset();
        ph = P_IDLE;
        e_ld_ready = 0; e_pwen = 0; e_dwen = 0; e_owner = 0; e_en = 0; e_rst = 0;
        e_busy = 0; e_done = 0; e_paddr = 0; e_pdata = 0; e_daddr = 0; e_err = 0; e_outc = 0;
        ld_open = 0; pend = 0; m_step_prev = 0; m_out_prev = 0; m_en_prev = 0;
        wr_ptr = 0; lowc = 0; wd = 0;
    endtask

    task automatic model_step();
        bit srise, orise, was_en, was_prev, had_pend, next_en;
        int pa, pd;
        srise = step && !m_step_prev;
        orise = core_stdout_en && !m_out_prev;
        was_en = e_en;
        was_prev = m_en_prev;
        m_step_prev = step; m_out_prev = core_stdout_en; m_en_prev = was_en;
        next_en = 0; had_pend = pend; pa = e_paddr; pd = e_pdata;
        pend = 0;
        if (abort) begin
            ph = P_IDLE;
        end else begin
            case (ph)
                P_IDLE, P_DONE: if (start) begin
                    e_done = 0; e_err = 0; e_outc = 0; e_daddr = 0; e_paddr = 0; wr_ptr = 0;
                    ph = P_CLEAR;
                end
                P_CLEAR: begin
                    if (e_daddr == 255) begin ph = P_LOAD; ld_open = 1; end
                    e_daddr = (e_daddr + 1) % 256;
                end
                P_LOAD: begin
                    if (ld_valid && ld_open) begin
                        pend = 1; e_paddr = wr_ptr; e_pdata = int'(ld_data);
                        if (ld_data == 8'd0 || wr_ptr == 255) ld_open = 0;
                        wr_ptr = (wr_ptr + 1) % 256;
                    end
                    if (had_pend && pd == 0) begin ph = P_RST; next_en = 1; end
                    else if (had_pend && pa == 255) begin ph = P_DONE; e_done = 1; e_err = 2; end
                end
                P_RST: begin
                    ph = P_RUN; lowc = 0; wd = 0; next_en = !pause || srise;
                end
                P_RUN: begin
                    if (was_prev) lowc = core_prog_ren ? 0 : ((lowc + 1 > 2) ? 2 : lowc + 1);
                    if (was_en) wd++;
                    if (orise && e_outc < 65535) e_outc++;
                    if (lowc == 2) begin ph = P_DONE; e_done = 1; e_err = 0; end
                    else if (wdog_limit != 0 && wd == int'(wdog_limit)) begin
                        ph = P_DONE; e_done = 1; e_err = 1;
                    end else next_en = !pause || srise;
                end
                default: ph = P_IDLE;
            endcase
        end
        e_en = next_en;
        e_pwen = pend;
        e_rst = (ph == P_RST);
        e_owner = (ph == P_RST) || (ph == P_RUN);
        e_dwen = (ph == P_CLEAR);
        e_ld_ready = (ph == P_LOAD) && ld_open;
        e_busy = !(ph == P_IDLE || ph == P_DONE);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Per-cycle compare plus tallies used by the scenario checks.
    bit cmp_on = 0;
    int dm_cnt, en_cnt;
    bit dm_seen [256];
    int pm_addrs [$];
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("ld_ready", int'(ld_ready), int'(e_ld_ready));
            chk("pmem_wen", int'(pmem_wen), int'(e_pwen));
            chk("pmem_addr", int'(pmem_addr), e_paddr);
            chk("pmem_wdata", int'(pmem_wdata), e_pdata);
            chk("dmem_wen", int'(dmem_wen), int'(e_dwen));
            chk("dmem_addr", int'(dmem_addr), e_daddr);
            chk("dmem_wdata", int'(dmem_wdata), 0);
            chk("mem_owner", int'(mem_owner), int'(e_owner));
            chk("core_en", int'(core_en), int'(e_en));
            chk("core_reset", int'(core_reset), int'(e_rst));
            chk("busy", int'(busy), int'(e_busy));
            chk("done", int'(done), int'(e_done));
            chk("err", int'(err), e_err);
            chk("out_count", int'(out_count), e_outc);
        end
        if (dmem_wen) begin dm_cnt++; dm_seen[dmem_addr] = 1; end
        if (pmem_wen) pm_addrs.push_back(int'(pmem_addr));
        if (core_en && !core_reset) en_cnt++;
    end

    task automatic clr_tally();
        dm_cnt = 0; en_cnt = 0; pm_addrs.delete();
        foreach (dm_seen[i]) dm_seen[i] = 0;
    endtask

    function automatic bit cond(input int which);
        case (which)
            0: return ld_ready;
            1: return !busy;
            default: return mem_owner && !core_reset;
        endcase
    endfunction

    task automatic wait_cond(input string nm, input int which, input int maxc);
        int n = 0;
        while (!cond(which) && n < maxc) begin @(negedge clk); n++; end
        if (n >= maxc) begin
            total++; bad++;
            $display("FAIL %s: condition not reached, waited %0d cycles, limit %0d", nm, n, maxc);
        end
    endtask

    task automatic pulse_start();
        start = 1; @(negedge clk); start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        ld_valid = 1; ld_data = b;
        while (!ld_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin
            total++; bad++;
            $display("FAIL ld_handshake: ld_ready got 0 expected 1 within %0d cycles", n);
        end
        @(negedge clk);
        ld_valid = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation still running, limit 5ms");
        $fatal(1, "timeout");
    end

    initial begin
        int nseen, len;
        bit do_abort;
        fc_rand = 0; halt_at = 1000000; out_a = -1; out_b = -1;
        clr_tally();
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1; cmp_on = 1;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_out_count", int'(out_count), 0);

        // Asynchronous reset in the middle of CLEAR
        pulse_start();
        repeat (40) @(negedge clk);
        @(posedge clk); #2 rst_n = 0; #1;
        chk("async_dmem_wen", int'(dmem_wen), 0);
        chk("async_dmem_addr", int'(dmem_addr), 0);
        chk("async_busy", int'(busy), 0);
        @(negedge clk); rst_n = 1; @(negedge clk);

        clr_tally();
        pulse_start();
        wait_cond("clear_to_load", 0, 400);
        nseen = 0;
        foreach (dm_seen[i]) nseen += int'(dm_seen[i]);
        chk("clear_write_cycles", dm_cnt, 256);
        chk("clear_addr_coverage", nseen, 256);

        // Abort after two bytes of LOAD, then restart from CLEAR address 0
        send_byte(8'h2B); send_byte(8'h2E);
        abort = 1; @(negedge clk); abort = 0;
        chk("abort_ld_ready", int'(ld_ready), 0);
        chk("abort_busy", int'(busy), 0);
        @(negedge clk);
        pulse_start();
        chk("restart_dmem_wen", int'(dmem_wen), 1);
        chk("restart_dmem_addr", int'(dmem_addr), 0);

        // "+.+." program: two outputs then halt
        halt_at = 12; out_a = 3; out_b = 7; wdog_limit = 16'd0;
        wait_cond("run1_load", 0, 400);
        clr_tally();
        send_byte(8'h2B); send_byte(8'h2E); send_byte(8'h2B); send_byte(8'h2E); send_byte(8'h00);
        wait_cond("run1_finish", 1, 500);
        chk("run1_done", int'(done), 1);
        chk("run1_err", int'(err), 0);
        chk("run1_out_count", int'(out_count), 2);
        chk("run1_pmem_writes", pm_addrs.size(), 5);
        for (int i = 0; i < 5 && i < pm_addrs.size(); i++) chk("run1_pmem_addr", pm_addrs[i], i);

        // "+[]" program never halts: watchdog at 100
        halt_at = 1000000; out_a = -1; out_b = -1; wdog_limit = 16'd100;
        pulse_start();
        wait_cond("run2_load", 0, 400);
        send_byte(8'h2B); send_byte(8'h5B); send_byte(8'h5D); send_byte(8'h00);
        clr_tally();
        wait_cond("run2_finish", 1, 2000);
        chk("run2_core_en_cycles", en_cnt, 100);
        chk("run2_err", int'(err), 1);
        chk("run2_done", int'(done), 1);

        // 256 nonzero bytes overflow program memory
        wdog_limit = 16'd0;
        pulse_start();
        wait_cond("run3_load", 0, 400);
        clr_tally();
        for (int i = 0; i < 256; i++) send_byte(8'h3E);
        wait_cond("run3_finish", 1, 10);
        chk("run3_err", int'(err), 2);
        chk("run3_done", int'(done), 1);
        chk("run3_core_en_cycles", en_cnt, 0);
        chk("run3_pmem_writes", pm_addrs.size(), 256);
        if (pm_addrs.size() > 0) chk("run3_last_addr", pm_addrs[$], 255);

        // Paused run advanced by three step pulses; limit 3 ends it
        pause = 1; wdog_limit = 16'd3;
        pulse_start();
        wait_cond("run4_load", 0, 400);
        send_byte(8'h2B); send_byte(8'h00);
        wait_cond("run4_in_run", 2, 20);
        clr_tally();
        repeat (3) @(negedge clk);
        chk("run4_paused_no_en", en_cnt, 0);
        for (int s = 0; s < 3; s++) begin
            step = 1; repeat (s + 1) @(negedge clk);
            step = 0; repeat (4) @(negedge clk);
        end
        wait_cond("run4_finish", 1, 50);
        chk("run4_core_en_cycles", en_cnt, 3);
        chk("run4_err", int'(err), 1);
        chk("run4_done", int'(done), 1);
        pause = 0;

        // Randomized runs against the model
        fc_rand = 1;
        for (int it = 0; it < 25; it++) begin
            wdog_limit = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(4, 80));
            pulse_start();
            wait_cond("rnd_load", 0, 400);
            len = $urandom_range(1, 12);
            do_abort = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_byte(8'($urandom_range(1, 255)));
                if (do_abort && k == len / 2) break;
            end
            if (do_abort) begin
                abort = 1; @(negedge clk); abort = 0;
            end else begin
                send_byte(8'h00);
                for (int c = 0; c < 1500 && busy; c++) begin
                    pause = ($urandom_range(0, 3) == 0);
                    step  = ($urandom_range(0, 2) == 0);
                    abort = ($urandom_range(0, 299) == 0);
                    @(negedge clk);
                end
                pause = 0; step = 0; abort = 0;
                if (busy) begin abort = 1; @(negedge clk); abort = 0; end
            end
            @(negedge clk);
        end

        cmp_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
